// File: rtl/fork_recv.sv
// fork_recv: 4-phase request/acknowledge receiver packing 32-bit halves into 64-bit AXI-Stream beats.
// Optional macro FORK_RECV_TIMEOUT_EN adds a holding register that closes idle frames after TIMEOUT_CYCLES.
module fork_recv #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [31:0] recv_len,
  input  logic        request,
  input  logic [31:0] din,
  output logic        acknowledge,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  output logic [31:0] data_cnt,
  output logic [31:0] tlast_cnt,
  output logic        read_hsked,
  output logic        o_rx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_LOW} state_t;
  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fork_recv: illegal parameter value");
  end

  // request synchronizer
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) req_sync_q <= '0;
    else                 req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], request};
  end
  assign req_s = req_sync_q[SYNC_STAGES-1];

  // FIFO status shared by the handshake FSM and the output side
  cnt_t count_q;
  ptr_t wr_ptr_q, rd_ptr_q;
  logic fifo_free, pop, push;
  beat_t push_beat, head;

  assign fifo_free = (count_q != cnt_t'(FIFO_DEPTH));

  // handshake FSM
  state_t state_q, state_d;
  logic   ack_d, capture;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q     <= IDLE;
      acknowledge <= 1'b0;
    end else begin
      state_q     <= state_d;
      acknowledge <= ack_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ack_d   = acknowledge;
    unique case (state_q)
      IDLE:     if (req_s && fifo_free) state_d = CAPTURE;
      CAPTURE: begin
        state_d = WAIT_LOW;
        ack_d   = 1'b1;
      end
      WAIT_LOW: if (!req_s) begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign capture = (state_q == CAPTURE);

  // word assembly and frame-length tracking
  logic        half_q, cap_lo, cap_hi, len_last, beat_clear;
  logic [31:0] lo_q, beat_cnt_q, len_q, eff_len;
  logic [63:0] word_new;

  assign cap_lo   = capture && !half_q;
  assign cap_hi   = capture &&  half_q;
  assign word_new = {din, lo_q};
  // the first beat of a frame decides with the live recv_len, later beats use the sampled one
  assign eff_len  = (beat_cnt_q == 32'd0) ? recv_len : len_q;
  assign len_last = (eff_len != 32'd0) && (beat_cnt_q == eff_len - 32'd1);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      half_q     <= 1'b0;
      lo_q       <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      if (capture) half_q <= ~half_q;
      if (cap_lo)  lo_q   <= din;
      if (cap_hi) begin
        if (beat_cnt_q == 32'd0) len_q <= recv_len;
        beat_cnt_q <= len_last ? 32'd0 : beat_cnt_q + 32'd1;
      end else if (beat_clear) begin
        beat_cnt_q <= 32'd0;
      end
    end
  end

`ifdef FORK_RECV_TIMEOUT_EN
  beat_t       hold_q;
  logic        hold_vld_q, tmo_hit, can_push;
  logic [31:0] tmo_q;

  assign tmo_hit    = hold_vld_q && !capture && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
  assign can_push   = fifo_free || pop;
  // a new word arriving flushes the held one; a length tlast or the idle timer flushes it early
  assign push       = hold_vld_q && (cap_hi || hold_q.last || tmo_hit) && can_push;
  assign push_beat  = '{last: hold_q.last || tmo_hit, data: hold_q.data};
  assign beat_clear = push && tmo_hit && !hold_q.last;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      if (cap_hi) begin
        hold_q     <= '{last: len_last, data: word_new};
        hold_vld_q <= 1'b1;
      end else if (push) begin
        hold_vld_q <= 1'b0;
      end
      if (!hold_vld_q || capture) tmo_q <= '0;
      else if (!tmo_hit)          tmo_q <= tmo_q + 32'd1;
    end
  end
`else
  assign push       = cap_hi;
  assign push_beat  = '{last: len_last, data: word_new};
  assign beat_clear = 1'b0;
`endif

  // output FIFO
  beat_t mem [FIFO_DEPTH];

  // NOTE: storage is left unreset; outputs are gated by tvalid and occupancy lives in reset pointers.
  always_ff @(posedge s_axis_aclk) begin
    if (push) mem[wr_ptr_q] <= push_beat;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: ;
      endcase
    end
  end

  assign head          = mem[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
  assign read_hsked    = m_axis_tvalid && m_axis_tready;
  assign pop           = read_hsked;

  // accepted-beat statistics
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      data_cnt  <= '0;
      tlast_cnt <= '0;
      o_rx_done <= 1'b0;
    end else begin
      if (read_hsked)                 data_cnt  <= data_cnt + 32'd1;
      if (read_hsked && m_axis_tlast) tlast_cnt <= tlast_cnt + 32'd1;
      o_rx_done <= read_hsked && m_axis_tlast;
    end
  end

endmodule

// File: tb/tb_fork_recv.sv
// Directed self-checking bench for fork_recv: handshake latency, packing, back-pressure, reset and frame tlast.
// Built with FORK_RECV_TIMEOUT_EN it runs the idle-timeout scenario instead of the default-build scenarios.
module tb_fork_recv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] recv_len = '0;
  logic        request = 1'b0;
  logic [31:0] din = '0;
  logic        acknowledge;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic [31:0] data_cnt;
  logic [31:0] tlast_cnt;
  logic        read_hsked;
  logic        o_rx_done;

  logic tready_set = 1'b0;
  logic tog_en = 1'b0;
  logic tog = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    tog = ~tog;
  end
  assign m_axis_tready = tready_set | (tog_en & tog);

  fork_recv #(
    .FIFO_DEPTH    (4),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .recv_len      (recv_len),
    .request       (request),
    .din           (din),
    .acknowledge   (acknowledge),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .data_cnt      (data_cnt),
    .tlast_cnt     (tlast_cnt),
    .read_hsked    (read_hsked),
    .o_rx_done     (o_rx_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  // output monitor: accepted beats, rx_done pulses, stability while stalled
  logic [64:0] beats[$];
  int          rx_done_cnt = 0;
  int          stall_cnt = 0;
  int          viol_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
      if (o_rx_done) rx_done_cnt++;
      if (prev_stall) begin
        stall_cnt++;
        if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat) viol_cnt++;
      end
    end
    prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
    prev_beat  = {m_axis_tlast, m_axis_tdata};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (acknowledge !== lvl && n < 40) begin
      tick(1);
      n++;
    end
    check(tag, 65'(acknowledge), 65'(lvl));
  endtask

  task automatic send_half(input logic [31:0] d);
    din = d;
    request = 1'b1;
    wait_ack(1'b1, "ack_rise");
    request = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic send_word(input logic [31:0] lo, input logic [31:0] hi);
    send_half(lo);
    send_half(hi);
  endtask

  task automatic drain();
    int n = 0;
    while (m_axis_tvalid && n < 100) begin
      tick(1);
      n++;
    end
    check("drain", 65'(m_axis_tvalid), 65'(0));
  endtask

  initial begin
    int base;
    int rxb;
    int n;
    logic [64:0] exp;

    tready_set = 1'b1;
    tick(3);
    check("rst_ack", 65'(acknowledge), 65'(0));
    check("rst_tvalid", 65'(m_axis_tvalid), 65'(0));
    check("rst_tlast", 65'(m_axis_tlast), 65'(0));
    check("rst_tdata", 65'(m_axis_tdata), 65'(0));
    check("rst_data_cnt", 65'(data_cnt), 65'(0));
    check("rst_tlast_cnt", 65'(tlast_cnt), 65'(0));
    check("rst_rx_done", 65'(o_rx_done), 65'(0));
    check("rst_hsked", 65'(read_hsked), 65'(0));
    rst_n = 1'b1;
    tick(2);

`ifdef FORK_RECV_TIMEOUT_EN
    // idle timeout closes the frame on the held third word
    recv_len = 32'd0;
    base = beats.size();
    send_word(32'h0000_0A00, 32'h0000_0B00);
    send_word(32'h0000_0A01, 32'h0000_0B01);
    send_half(32'h0000_0A02);
    din = 32'h0000_0B02;
    request = 1'b1;
    wait_ack(1'b1, "tmo_ack");
    request = 1'b0;
    n = 0;
    while (!(m_axis_tvalid && m_axis_tlast) && n < 40) begin
      tick(1);
      n++;
    end
    check("tmo_latency", 65'(n), 65'(16));
    tick(3);
    check("tmo_n_beats", 65'(beats.size() - base), 65'(3));
    check("tmo_beat0", beats[base], {1'b0, 64'h0000_0B00_0000_0A00});
    check("tmo_beat1", beats[base + 1], {1'b0, 64'h0000_0B01_0000_0A01});
    check("tmo_beat2", beats[base + 2], {1'b1, 64'h0000_0B02_0000_0A02});
    check("tmo_tlast_cnt", 65'(tlast_cnt), 65'(1));
    check("tmo_data_cnt", 65'(data_cnt), 65'(3));
`else
    // two-beat frame, ack and tvalid latency
    recv_len = 32'd2;
    base = beats.size();
    rxb = rx_done_cnt;
    din = 32'h1111_1111;
    request = 1'b1;
    tick(3);
    check("ack_early", 65'(acknowledge), 65'(0));
    tick(1);
    check("ack_latency", 65'(acknowledge), 65'(1));
    request = 1'b0;
    wait_ack(1'b0, "ack_fall");
    din = 32'h2222_2222;
    request = 1'b1;
    wait_ack(1'b1, "ack_rise");
    check("tvalid_latency", 65'(m_axis_tvalid), 65'(1));
    request = 1'b0;
    wait_ack(1'b0, "ack_fall");
    send_word(32'h3333_3333, 32'h4444_4444);
    tick(3);
    check("f2_n_beats", 65'(beats.size() - base), 65'(2));
    check("f2_beat0", beats[base], {1'b0, 64'h2222_2222_1111_1111});
    check("f2_beat1", beats[base + 1], {1'b1, 64'h4444_4444_3333_3333});
    check("f2_data_cnt", 65'(data_cnt), 65'(2));
    check("f2_tlast_cnt", 65'(tlast_cnt), 65'(1));
    check("f2_rx_done", 65'(rx_done_cnt - rxb), 65'(1));

    // FIFO full stalls the sender, nothing lost
    recv_len = 32'd0;
    tready_set = 1'b0;
    base = beats.size();
    for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
    tick(2);
    check("full_tvalid", 65'(m_axis_tvalid), 65'(1));
    check("full_head", {m_axis_tlast, m_axis_tdata}, {1'b0, 64'hB000_0000_A000_0000});
    check("full_data_cnt", 65'(data_cnt), 65'(2));
    din = 32'hA000_0004;
    request = 1'b1;
    tick(20);
    check("full_ack_low", 65'(acknowledge), 65'(0));
    tready_set = 1'b1;
    wait_ack(1'b1, "full_ack_rise");
    request = 1'b0;
    wait_ack(1'b0, "ack_fall");
    send_half(32'hB000_0004);
    drain();
    check("full_n_beats", 65'(beats.size() - base), 65'(5));
    for (int i = 0; i < 5; i++) begin
      exp = {1'b0, 32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      check("full_order", beats[base + i], exp);
    end
    check("full_data_cnt2", 65'(data_cnt), 65'(7));

    // tready toggling with a backlog in the FIFO
    base = beats.size();
    tready_set = 1'b0;
    send_word(32'hC000_0000, 32'hD000_0000);
    send_word(32'hC000_0001, 32'hD000_0001);
    tog_en = 1'b1;
    send_word(32'hC000_0002, 32'hD000_0002);
    send_word(32'hC000_0003, 32'hD000_0003);
    drain();
    tog_en = 1'b0;
    check("tog_n_beats", 65'(beats.size() - base), 65'(4));
    for (int i = 0; i < 4; i++) begin
      exp = {1'b0, 32'hD000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
      check("tog_order", beats[base + i], exp);
    end
    check("tog_data_cnt", 65'(data_cnt), 65'(11));
    check("tog_stalled", 65'(stall_cnt > 0), 65'(1));
    check("tog_stable", 65'(viol_cnt), 65'(0));

    // reset between halves, with a word already queued
    recv_len = 32'd1;
    send_word(32'hE000_0001, 32'hE000_0002);
    check("prerst_tvalid", 65'(m_axis_tvalid), 65'(1));
    din = 32'hDEAD_0001;
    request = 1'b1;
    wait_ack(1'b1, "prerst_ack");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_ack", 65'(acknowledge), 65'(0));
    check("rst_async_tvalid", 65'(m_axis_tvalid), 65'(0));
    check("rst_async_tdata", 65'(m_axis_tdata), 65'(0));
    request = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    base = beats.size();
    tready_set = 1'b1;
    send_word(32'h5555_0000, 32'h6666_0000);
    tick(3);
    check("rst_n_beats", 65'(beats.size() - base), 65'(1));
    check("rst_beat", beats[base], {1'b1, 64'h6666_0000_5555_0000});
    check("rst_data_cnt2", 65'(data_cnt), 65'(1));
    check("rst_tlast_cnt2", 65'(tlast_cnt), 65'(1));

    // recv_len changes mid-frame
    recv_len = 32'd4;
    base = beats.size();
    send_word(32'hF000_0000, 32'h0F00_0000);
    recv_len = 32'd2;
    for (int i = 1; i < 6; i++) send_word(32'hF000_0000 + 32'(i), 32'h0F00_0000 + 32'(i));
    tick(3);
    check("len_n_beats", 65'(beats.size() - base), 65'(6));
    for (int i = 0; i < 6; i++) begin
      exp = {(i == 3 || i == 5), 32'h0F00_0000 + 32'(i), 32'hF000_0000 + 32'(i)};
      check("len_beat", beats[base + i], exp);
    end
    check("len_tlast_cnt", 65'(tlast_cnt), 65'(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
